// File: rtl/t05_cb_decoder.sv
`timescale 1ns/1ps
// Huffman tree-walk decoder: walks HTREE nodes from the root, one bitstream bit per step.
// Each leaf is emitted on a valid/ready port and the walk restarts at the root.
// The decoder stops after total_chars characters; an empty child or depth overflow is a sticky error.
module t05_cb_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [6:0]       max_index,
    input  logic [CNT_W-1:0] total_chars,
    output logic             fetch_req,
    output logic [6:0]       fetch_index,
    input  logic             fetch_valid,
    input  logic [70:0]      h_element,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             char_valid,
    output logic [7:0]       char_out,
    input  logic             char_ready,
    output logic [CNT_W-1:0] char_count,
    output logic [6:0]       depth,
    output logic [3:0]       finished,
    output logic             error
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_WAIT_BIT = 3'd2;
    localparam logic [2:0] S_EMIT     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_ERROR    = 3'd5;

    localparam logic [8:0] CHILD_EMPTY = 9'h180;
    localparam logic [6:0] DEPTH_MAX   = 7'd127;

    logic [2:0]       state_q, state_d;
    logic [6:0]       fetch_index_q, fetch_index_d;
    logic [6:0]       root_q, root_d;
    logic [6:0]       depth_q, depth_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [8:0]       least1_q, least1_d;
    logic [8:0]       least2_q, least2_d;
    logic [7:0]       char_q, char_d;

    logic [8:0]       child;
    logic [CNT_W-1:0] count_inc;
    logic             elem_unused;

    assign child       = bit_in ? least2_q : least1_q;
    assign count_inc   = count_q + CNT_W'(1);
    assign elem_unused = ^{h_element[70:64], h_element[45:0]};

    always_comb begin
        state_d       = state_q;
        fetch_index_d = fetch_index_q;
        root_d        = root_q;
        depth_d       = depth_q;
        count_d       = count_q;
        total_d       = total_q;
        least1_d      = least1_q;
        least2_d      = least2_q;
        char_d        = char_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // Root and length are captured here so later input changes cannot disturb a walk.
                if (start) begin
                    count_d       = '0;
                    depth_d       = '0;
                    fetch_index_d = max_index;
                    root_d        = max_index;
                    total_d       = total_chars;
                    state_d       = (total_chars == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_valid) begin
                    least1_d = h_element[63:55];
                    least2_d = h_element[54:46];
                    state_d  = S_WAIT_BIT;
                end
            end
            S_WAIT_BIT: begin
                if (bit_valid) begin
                    if (child == CHILD_EMPTY) begin
                        state_d = S_ERROR;
                    end else if (child[8]) begin
                        if (depth_q == DEPTH_MAX) begin
                            state_d = S_ERROR;
                        end else begin
                            fetch_index_d = child[6:0];
                            depth_d       = depth_q + 7'd1;
                            state_d       = S_FETCH;
                        end
                    end else begin
                        char_d  = child[7:0];
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (char_ready) begin
                    count_d = count_inc;
                    depth_d = '0;
                    if (count_inc == total_q) begin
                        state_d = S_DONE;
                    end else begin
                        fetch_index_d = root_q;
                        state_d       = S_FETCH;
                    end
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= S_IDLE;
            fetch_index_q <= '0;
            root_q        <= '0;
            depth_q       <= '0;
            count_q       <= '0;
            total_q       <= '0;
            least1_q      <= '0;
            least2_q      <= '0;
            char_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_index_q <= fetch_index_d;
            root_q        <= root_d;
            depth_q       <= depth_d;
            count_q       <= count_d;
            total_q       <= total_d;
            least1_q      <= least1_d;
            least2_q      <= least2_d;
            char_q        <= char_d;
        end
    end

    assign fetch_req   = (state_q == S_FETCH);
    assign fetch_index = fetch_index_q;
    assign bit_ready   = (state_q == S_WAIT_BIT);
    assign char_valid  = (state_q == S_EMIT);
    assign char_out    = char_q;
    assign char_count  = count_q;
    assign depth       = depth_q;
    assign finished    = (state_q == S_DONE) ? 4'b0101 : 4'b0000;
    assign error       = (state_q == S_ERROR);
endmodule

// File: tb/tb_t05_cb_decoder.sv
`timescale 1ns/1ps
// Bench for t05_cb_decoder: an SRAM responder, bit source and char sink around the DUT,
// with expected characters derived by walking the bench's own copy of the tree.
module tb_t05_cb_decoder;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             start = 1'b0;
    logic [6:0]       max_index = '0;
    logic [CNT_W-1:0] total_chars = '0;
    logic             fetch_req;
    logic [6:0]       fetch_index;
    logic             fetch_valid = 1'b0;
    logic [70:0]      h_element = '0;
    logic             bit_valid = 1'b0;
    logic             bit_in = 1'b0;
    logic             bit_ready;
    logic             char_valid;
    logic [7:0]       char_out;
    logic             char_ready = 1'b0;
    logic [CNT_W-1:0] char_count;
    logic [6:0]       depth;
    logic [3:0]       finished;
    logic             error;

    int total = 0;
    int bad = 0;

    logic [8:0] l1 [128];
    logic [8:0] l2 [128];
    bit         stim_bits[$];
    bit         bit_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         exp_err;
    int         exp_used;

    int  bits_consumed, fetch_cyc, rdy_cyc, first_fetch, first_rdy;
    bit  first_seen;
    int  fetch_delay = 0;
    int  ready_mode = 0;
    bit  bit_gaps = 0;
    bit  fv_noise = 0;
    bit  pending = 0;
    bit  fv_drv = 0;
    logic [6:0] pend_idx = '0;
    int  wcnt = 0;

    t05_cb_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .nrst(nrst), .start(start), .max_index(max_index),
        .total_chars(total_chars), .fetch_req(fetch_req), .fetch_index(fetch_index),
        .fetch_valid(fetch_valid), .h_element(h_element), .bit_valid(bit_valid),
        .bit_in(bit_in), .bit_ready(bit_ready), .char_valid(char_valid),
        .char_out(char_out), .char_ready(char_ready), .char_count(char_count),
        .depth(depth), .finished(finished), .error(error)
    );

    always #5 clk = ~clk;

    // Drivers change inputs on the falling edge; the SRAM responder also checks request stability.
    always @(negedge clk) begin
        if (fv_drv) pending = 1'b0;
        fv_drv = 1'b0;
        if (fetch_req) begin
            if (pending) begin
                total++;
                if (fetch_index !== pend_idx) begin
                    bad++;
                    $display("FAIL fetch_index_stable got=%0d want=%0d", fetch_index, pend_idx);
                end
            end else begin
                pending  = 1'b1;
                pend_idx = fetch_index;
                wcnt     = 0;
            end
            if (wcnt >= fetch_delay) begin
                fetch_valid = 1'b1;
                h_element   = {7'($urandom), l1[fetch_index], l2[fetch_index], 46'({$urandom, $urandom})};
                fv_drv      = 1'b1;
            end else begin
                fetch_valid = 1'b0;
                wcnt++;
            end
        end else begin
            pending     = 1'b0;
            fetch_valid = fv_noise ? 1'($urandom) : 1'b0;
            h_element   = 71'({$urandom, $urandom, $urandom});
        end
        if (bit_q.size() > 0 && (!bit_gaps || $urandom_range(3) != 0)) begin
            bit_valid = 1'b1;
            bit_in    = bit_q[0];
        end else begin
            bit_valid = 1'b0;
            bit_in    = 1'($urandom);
        end
        case (ready_mode)
            0:       char_ready = 1'b1;
            1:       char_ready = 1'($urandom);
            default: char_ready = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        if (nrst) begin
            if (bit_valid && bit_ready) begin
                bit_q.delete(0);
                bits_consumed++;
            end
            if (char_valid && char_ready) got_q.push_back(char_out);
            if (fetch_req) fetch_cyc++;
            if (bit_ready) rdy_cyc++;
            if (char_valid && !first_seen) begin
                first_seen  = 1'b1;
                first_fetch = fetch_cyc;
                first_rdy   = rdy_cyc;
            end
        end
    end

    // Reference: walk the tree with the stimulus bits, restarting at the root after each leaf.
    task automatic model_run(input int root, input int tot);
        int node, d, n;
        logic [8:0] c;
        exp_q.delete();
        exp_err = 1'b0; exp_used = 0; node = root; d = 0; n = 0;
        while (n < tot && !exp_err && exp_used < stim_bits.size()) begin
            c = stim_bits[exp_used] ? l2[node] : l1[node];
            exp_used++;
            if (c == 9'h180) exp_err = 1'b1;
            else if (c[8]) begin
                if (d == 127) exp_err = 1'b1;
                else begin d++; node = int'(c[6:0]); end
            end else begin
                exp_q.push_back(c[7:0]); n++; node = root; d = 0;
            end
        end
    endtask

    task automatic clear_tree();
        for (int i = 0; i < 128; i++) begin l1[i] = 9'h180; l2[i] = 9'h180; end
    endtask

    task automatic abc_tree();
        clear_tree();
        l1[2] = 9'h101; l2[2] = 9'h043;
        l1[1] = 9'h041; l2[1] = 9'h042;
    endtask

    task automatic clear_run();
        bit_q.delete(); got_q.delete();
        bits_consumed = 0; fetch_cyc = 0; rdy_cyc = 0; first_seen = 1'b0;
        first_fetch = 0; first_rdy = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [6:0] mi, input logic [CNT_W-1:0] tc);
        @(negedge clk);
        max_index = mi; total_chars = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        max_index = 7'($urandom); total_chars = CNT_W'($urandom);
    endtask

    task automatic wait_end(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (finished == 4'b0101 || error) begin to = 1'b0; break; end
        end
    endtask

    task automatic wait_char(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (char_valid) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({fetch_req, fetch_index, bit_ready, char_valid, char_out, char_count, depth, finished, error} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got req=%b idx=%0d rdy=%b cv=%b ch=%h cnt=%0d dep=%0d fin=%b err=%b want all 0",
                     fetch_req, fetch_index, bit_ready, char_valid, char_out, char_count, depth, finished, error);
        end
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({fetch_req, bit_ready, char_valid, finished, error} !== '0) begin
            bad++;
            $display("FAIL idle_after_reset got req=%b rdy=%b cv=%b fin=%b err=%b want all 0",
                     fetch_req, bit_ready, char_valid, finished, error);
        end
    endtask

    task automatic test_basic(input int delay);
        bit to;
        do_reset(); abc_tree();
        stim_bits = '{0, 0, 0, 1, 1};
        model_run(2, 3);
        clear_run(); bit_q = stim_bits; fetch_delay = delay; ready_mode = 0;
        pulse_start(7'd2, CNT_W'(3));
        wait_end(400, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout delay=%0d got timeout want done", delay); end
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_nchars got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_char%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (finished !== 4'b0101) begin bad++; $display("FAIL basic_finished got=%b want=0101", finished); end
        total++; if (char_count !== CNT_W'(3)) begin bad++; $display("FAIL basic_count got=%0d want=3", char_count); end
        total++; if (bits_consumed != 5) begin bad++; $display("FAIL basic_bits got=%0d want=5", bits_consumed); end
        total++; if (fetch_cyc != 5 * (delay + 1)) begin bad++; $display("FAIL basic_fetch_cycles got=%0d want=%0d", fetch_cyc, 5 * (delay + 1)); end
        if (delay == 0) begin
            total++;
            if (first_fetch != 2 || first_rdy != 2) begin
                bad++; $display("FAIL first_char_latency got fetch=%0d wait=%0d want 2 and 2", first_fetch, first_rdy);
            end
        end
        fetch_delay = 0;
    endtask

    task automatic test_stall();
        bit to;
        do_reset(); abc_tree();
        stim_bits = '{0, 0, 0, 1, 1};
        model_run(2, 3);
        clear_run(); bit_q = stim_bits; ready_mode = 2;
        pulse_start(7'd2, CNT_W'(3));
        wait_char(100, to);
        total++; if (to) begin bad++; $display("FAIL stall_no_char got timeout want char_valid"); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (char_valid !== 1'b1 || char_out !== 8'h41 || bit_ready !== 1'b0 || fetch_req !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d got cv=%b ch=%h rdy=%b req=%b want 1 41 0 0", k, char_valid, char_out, bit_ready, fetch_req);
            end
        end
        total++; if (bits_consumed != 2) begin bad++; $display("FAIL stall_bits got=%0d want=2", bits_consumed); end
        ready_mode = 0;
        wait_end(200, to);
        total++;
        if (to || got_q.size() != 3 || char_count !== CNT_W'(3)) begin
            bad++; $display("FAIL stall_finish got n=%0d cnt=%0d want 3 3", got_q.size(), char_count);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_char%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_single_leaf();
        bit to;
        do_reset(); clear_tree();
        l1[5] = 9'h05A; l2[5] = 9'h180;
        stim_bits = '{0, 0};
        model_run(5, 2);
        clear_run(); bit_q = stim_bits; ready_mode = 0;
        pulse_start(7'd5, CNT_W'(2));
        wait_end(200, to);
        total++;
        if (to || got_q.size() != 2 || finished !== 4'b0101 || error !== 1'b0) begin
            bad++; $display("FAIL leaf_ok got n=%0d fin=%b err=%b want 2 0101 0", got_q.size(), finished, error);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL leaf_char%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        stim_bits = '{0, 1};
        model_run(5, 2);
        clear_run(); bit_q = stim_bits;
        pulse_start(7'd5, CNT_W'(2));
        wait_end(200, to);
        total++;
        if (to || error !== exp_err || finished !== 4'b0000) begin
            bad++; $display("FAIL leaf_err got err=%b fin=%b want %b 0000", error, finished, exp_err);
        end
        total++;
        if (got_q.size() != exp_q.size() || char_count !== CNT_W'(exp_q.size())) begin
            bad++; $display("FAIL leaf_err_count got n=%0d cnt=%0d want %0d", got_q.size(), char_count, exp_q.size());
        end
        pulse_start(7'd5, CNT_W'(2));
        repeat (3) @(negedge clk);
        total++;
        if (error !== 1'b1 || fetch_req !== 1'b0 || bit_ready !== 1'b0) begin
            bad++; $display("FAIL error_sticky got err=%b req=%b rdy=%b want 1 0 0", error, fetch_req, bit_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        do_reset(); abc_tree();
        stim_bits = '{0, 0, 0, 1, 1};
        model_run(2, 3);
        clear_run(); bit_q = stim_bits; ready_mode = 2;
        pulse_start(7'd2, CNT_W'(3));
        wait_char(100, to);
        #2 nrst = 1'b0;
        #1;
        total++;
        if (to || {fetch_req, fetch_index, bit_ready, char_valid, char_out, char_count, depth, finished, error} !== '0) begin
            bad++; $display("FAIL reset_mid_outputs got cv=%b ch=%h cnt=%0d dep=%0d want all 0", char_valid, char_out, char_count, depth);
        end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL reset_mid_partial got=%0d want=0", got_q.size()); end
        @(negedge clk);
        nrst = 1'b1; ready_mode = 0;
        clear_run(); bit_q = stim_bits;
        pulse_start(7'd2, CNT_W'(3));
        total++;
        if (char_count !== '0 || depth !== '0 || fetch_index !== 7'd2) begin
            bad++; $display("FAIL restart_state got cnt=%0d dep=%0d idx=%0d want 0 0 2", char_count, depth, fetch_index);
        end
        wait_end(200, to);
        total++; if (to || got_q.size() != 3) begin bad++; $display("FAIL restart_n got=%0d want=3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL restart_char%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_zero_chars();
        do_reset(); abc_tree();
        clear_run(); bit_q = '{0, 1, 0};
        pulse_start(7'd2, CNT_W'(0));
        total++; if (finished !== 4'b0101) begin bad++; $display("FAIL zero_done got=%b want=0101", finished); end
        repeat (5) @(negedge clk);
        total++;
        if (fetch_cyc != 0 || rdy_cyc != 0 || bits_consumed != 0 || finished !== 4'b0101) begin
            bad++; $display("FAIL zero_idle got fetch=%0d wait=%0d bits=%0d fin=%b want 0 0 0 0101", fetch_cyc, rdy_cyc, bits_consumed, finished);
        end
    endtask

    task automatic test_depth_limit();
        bit to;
        do_reset(); clear_tree();
        l1[7] = 9'h107; l2[7] = 9'h042;
        stim_bits.delete();
        for (int i = 0; i < 200; i++) stim_bits.push_back(1'b0);
        model_run(7, 1);
        clear_run(); bit_q = stim_bits; ready_mode = 0;
        pulse_start(7'd7, CNT_W'(1));
        wait_end(1000, to);
        total++;
        if (to || error !== exp_err || bits_consumed != exp_used || depth !== 7'd127 || got_q.size() != 0) begin
            bad++; $display("FAIL depth_limit got err=%b bits=%0d dep=%0d n=%0d want %b %0d 127 0",
                            error, bits_consumed, depth, got_q.size(), exp_err, exp_used);
        end
    endtask

    task automatic test_random();
        bit to, stop;
        int k, base, root, tot, node;
        logic [8:0] c;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            clear_tree();
            k = $urandom_range(2, 12);
            base = $urandom_range(0, 127 - k);
            for (int i = 0; i < k; i++) begin
                for (int s = 0; s < 2; s++) begin
                    int r = $urandom_range(0, 7);
                    if (it % 4 == 3 && r == 0) c = 9'h180;
                    else if (i > 0 && r < 4) c = {2'b10, 7'(base + $urandom_range(0, i - 1))};
                    else c = {1'b0, 8'($urandom)};
                    if (s == 0) l1[base + i] = c; else l2[base + i] = c;
                end
            end
            root = base + k - 1;
            tot = $urandom_range(1, 10);
            stim_bits.delete(); stop = 1'b0;
            for (int n = 0; n < tot && !stop; n++) begin
                node = root;
                for (int g = 0; g < 64; g++) begin
                    bit b = 1'($urandom);
                    stim_bits.push_back(b);
                    c = b ? l2[node] : l1[node];
                    if (c == 9'h180) begin stop = 1'b1; break; end
                    if (!c[8]) break;
                    node = int'(c[6:0]);
                end
            end
            model_run(root, tot);
            clear_run(); bit_q = stim_bits;
            fetch_delay = $urandom_range(0, 2); ready_mode = 1; bit_gaps = 1'b1; fv_noise = 1'b1;
            pulse_start(7'(root), CNT_W'(tot));
            wait_end(3000, to);
            total++;
            if (to || error !== exp_err || finished !== (exp_err ? 4'b0000 : 4'b0101)) begin
                bad++; $display("FAIL rand%0d_end got to=%b err=%b fin=%b want err=%b", it, to, error, finished, exp_err);
            end
            total++;
            if (bits_consumed != exp_used || got_q.size() != exp_q.size() || char_count !== CNT_W'(exp_q.size())) begin
                bad++; $display("FAIL rand%0d_counts got bits=%0d n=%0d cnt=%0d want %0d %0d", it, bits_consumed,
                                got_q.size(), char_count, exp_used, exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_char%0d got=%h want=%h", it, i, got_q[i], exp_q[i]); end
            end
            if (error || to) do_reset();
        end
        fetch_delay = 0; ready_mode = 0; bit_gaps = 1'b0; fv_noise = 1'b0;
    endtask

    initial begin
        clear_tree();
        test_reset();
        test_basic(0);
        test_stall();
        test_single_leaf();
        test_basic(3);
        test_reset_mid();
        test_zero_chars();
        test_depth_limit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/t05_cb_decoder.md
Name: t05_cb_decoder

Overview:
Huffman tree-walk decoder, the decode-side counterpart of codebook synthesis. It consumes a serial bitstream one bit per handshake and fetches HTREE elements from SRAM by index, starting from the root (max_index). It walks left on 0 and right on 1, emits each leaf character on a valid/ready output, and returns to the root after every leaf. It stops after a programmed number of characters and reports completion to the controller.

Parameters:
CNT_W, 16, width of character counter and total_chars.

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begin decode (accepted in IDLE or DONE only)
max_index  in  7  HTREE root index
total_chars  in  CNT_W  number of characters to decode
fetch_req  out  1  HTREE read request, held until fetch_valid
fetch_index  out  7  HTREE index to read
fetch_valid  in  1  h_element valid this cycle
h_element  in  71  HTREE element; least1=[63:55] (left child), least2=[54:46] (right child)
bit_valid  in  1  bitstream bit available
bit_in  in  1  bitstream bit (0=left, 1=right)
bit_ready  out  1  decoder accepts a bit this cycle
char_valid  out  1  decoded character valid
char_out  out  8  decoded character
char_ready  in  1  downstream accepts character
char_count  out  CNT_W  characters emitted so far
depth  out  7  current tree depth (edges from root)
finished  out  4  4'b0101 in DONE, else 0
error  out  1  sticky decode error

Behaviour:
- Child encoding (9 bits): 9'h180 = empty. Otherwise bit8=1 is a sum node with child index in [6:0]; bit8=0 is a leaf with character in [7:0].
- Reset (async, nrst=0): state IDLE. All outputs 0: fetch_req, fetch_index, bit_ready, char_valid, char_out, char_count, depth, finished, error. Node register (least1/least2) cleared. Reset mid-walk aborts immediately; no partial char is emitted.
- States: IDLE, FETCH, WAIT_BIT, EMIT, DONE, ERROR.
- IDLE: on start, char_count<=0, depth<=0, fetch_index<=max_index.
  - If total_chars==0, go to DONE.
  - Otherwise go to FETCH.
- FETCH: fetch_req=1, fetch_index stable. On the fetch_valid cycle, register h_element[63:55] and h_element[54:46], then go to WAIT_BIT. Minimum one cycle in FETCH.
- WAIT_BIT: bit_ready=1. On bit_valid, the bit is consumed that cycle and child = bit_in ? least2 : least1.
  - Empty child: go to ERROR.
  - Sum child: fetch_index<=child[6:0], depth<=depth+1, go to FETCH. If depth==127, go to ERROR instead.
  - Leaf child: char_out<=child[7:0], go to EMIT.
- EMIT: char_valid=1, char_out held stable until char_ready. On the char_valid&&char_ready cycle:
  - char_count<=char_count+1 and depth<=0.
  - If char_count+1==total_chars, go to DONE.
  - Otherwise fetch_index<=max_index and go to FETCH (root re-fetched for every character).
  - bit_ready=0 throughout EMIT.
- DONE: finished=4'b0101. All handshakes idle. Holds until start, which restarts exactly as from IDLE. total_chars and max_index are sampled only at start.
- ERROR: error=1, finished=0, all handshakes idle. Sticky until reset; start is ignored.
- Single-leaf tree (root least1=leaf, least2=9'h180): bit 0 emits the char; bit 1 goes to ERROR.
- Simultaneous events:
  - fetch_valid outside FETCH is ignored.
  - bit_valid is accepted only in WAIT_BIT.
  - start outside IDLE/DONE is ignored.
- Per-character latency from root, depth d, 1-cycle SRAM, no stalls: d bits consumed; (d FETCH + d WAIT_BIT + 1 EMIT) cycles.

Test Plan:
- Tree: root idx 2 = {least1=sum idx1 (9'h101), least2=leaf 'C' (9'h043)}; idx1 = {'A' 9'h041, 'B' 9'h042}. max_index=2, total_chars=3, bits 0,0,0,1,1 → chars 0x41, 0x42, 0x43 in order; finished=4'b0101; char_count=3; 5 bits consumed.
- Same tree, char_ready low 4 cycles on first char → char_valid and char_out=0x41 held; bit_ready=0; no fetch issued until accept.
- Single-leaf tree root {9'h05A, 9'h180}, total_chars=2, bits 0,0 → two 0x5A then DONE. Repeat with bits 0,1 → one 0x5A then error=1, finished=0.
- fetch_valid delayed 3 cycles per read → fetch_req and fetch_index stay stable until fetch_valid; decoded output identical to the first scenario.
- nrst asserted while in EMIT → all outputs 0 asynchronously; after release and a new start, decode restarts at root with char_count=0.
- total_chars=0 with start → DONE the next cycle, with no fetch_req or bit_ready ever asserted.
